// File: rtl/mtl2_touch_pkg.sv
// Shared encodings for the MTL2 touch sequencer: I2C command ops, FSM states,
// frame layout and small state-decode helpers.
package mtl2_touch_pkg;

  // Byte-engine command opcodes
  localparam logic [2:0] OP_START_WR     = 3'd0;
  localparam logic [2:0] OP_WR           = 3'd1;
  localparam logic [2:0] OP_RSTART_WR    = 3'd2;
  localparam logic [2:0] OP_RD_ACK       = 3'd3;
  localparam logic [2:0] OP_RD_NACK_STOP = 3'd4;
  localparam logic [2:0] OP_STOP         = 3'd5;

  // Touch frame: count, XH, XL, YH, YL
  localparam int unsigned FRAME_LEN = 5;
  localparam logic [2:0] BYTE_COUNT = 3'd0;
  localparam logic [2:0] BYTE_XH    = 3'd1;
  localparam logic [2:0] BYTE_XL    = 3'd2;
  localparam logic [2:0] BYTE_YH    = 3'd3;
  localparam logic [2:0] BYTE_YL    = 3'(FRAME_LEN - 1);

  typedef enum logic [3:0] {
    StIdle,
    StAddrW,
    StReg,
    StAddrR,
    StRd0,
    StRd1,
    StRd2,
    StRd3,
    StRd4,
    StPublish,
    StAbort
  } state_e;

  function automatic logic [2:0] op_of(state_e s);
    case (s)
      StAddrW:                     return OP_START_WR;
      StReg:                       return OP_WR;
      StAddrR:                     return OP_RSTART_WR;
      StRd0, StRd1, StRd2, StRd3:  return OP_RD_ACK;
      StRd4:                       return OP_RD_NACK_STOP;
      StAbort:                     return OP_STOP;
      default:                     return 3'd0;
    endcase
  endfunction

  // States that present a command to the byte engine
  function automatic logic is_cmd_state(state_e s);
    return (s != StIdle) && (s != StPublish);
  endfunction

  // Only write-op responses may carry a meaningful NACK
  function automatic logic is_write_state(state_e s);
    return (s == StAddrW) || (s == StReg) || (s == StAddrR);
  endfunction

  function automatic logic is_read_state(state_e s);
    return (s == StRd0) || (s == StRd1) || (s == StRd2) || (s == StRd3) || (s == StRd4);
  endfunction

  function automatic logic [2:0] rd_index(state_e s);
    case (s)
      StRd0:   return BYTE_COUNT;
      StRd1:   return BYTE_XH;
      StRd2:   return BYTE_XL;
      StRd3:   return BYTE_YH;
      StRd4:   return BYTE_YL;
      default: return 3'd0;
    endcase
  endfunction

  function automatic state_e next_state(state_e s);
    case (s)
      StAddrW: return StReg;
      StReg:   return StAddrR;
      StAddrR: return StRd0;
      StRd0:   return StRd1;
      StRd1:   return StRd2;
      StRd2:   return StRd3;
      StRd3:   return StRd4;
      StRd4:   return StPublish;
      default: return StIdle;
    endcase
  endfunction

endpackage

// File: rtl/mtl2_int_sync.sv
// Two-flop synchronizer for the active-low touch interrupt plus falling-edge
// detect. All flops reset to 1 so reset never manufactures an edge.
module mtl2_int_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_n_i,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the raw pin through the synchronizer and one history flop
  always_comb begin
    meta_d = async_n_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronous active-low reset to the deasserted level
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/mtl2_touch_sequencer.sv
// Reads one touch frame from the MTL2 controller over a byte-level I2C master
// each time the panel interrupt falls, and publishes the first touch point.
module mtl2_touch_sequencer
  import mtl2_touch_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = 7'h38,
  parameter logic [7:0]  REG_BASE       = 8'h02,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TW             = 20
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        touch_int_n,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_data,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_nack,
  output logic        busy,
  output logic        touch_valid,
  output logic [3:0]  touch_count,
  output logic [11:0] touch_x,
  output logic [11:0] touch_y,
  output logic        err_nack,
  output logic        err_timeout
);

  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] data_of(state_e s);
    case (s)
      StAddrW: return {DEV_ADDR, 1'b0};
      StReg:   return REG_BASE;
      StAddrR: return {DEV_ADDR, 1'b1};
      default: return 8'h00;
    endcase
  endfunction

  logic int_fall;

  mtl2_int_sync u_int_sync (
    .clk_i     (clk_50),
    .rst_ni    (reset_n),
    .async_n_i (touch_int_n),
    .fall_o    (int_fall)
  );

  state_e        state_q, state_d;
  logic          acc_q, acc_d;          // current command accepted, awaiting response
  logic          pending_q, pending_d;
  logic [TW-1:0] tmo_q, tmo_d;
  // Only the bits that reach the outputs are kept; YL goes straight to touch_y
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    xh_q, xh_d;
  logic [7:0]    xl_q, xl_d;
  logic [3:0]    yh_q, yh_d;

  logic          cmd_valid_q, cmd_valid_d;
  logic [2:0]    cmd_op_q, cmd_op_d;
  logic [7:0]    cmd_data_q, cmd_data_d;
  logic          busy_q, busy_d;
  logic          touch_valid_q, touch_valid_d;
  logic [3:0]    touch_count_q, touch_count_d;
  logic [11:0]   touch_x_q, touch_x_d;
  logic [11:0]   touch_y_q, touch_y_d;
  logic          err_nack_q, err_nack_d;
  logic          err_timeout_q, err_timeout_d;

  logic accept;
  logic got_rsp;

  assign accept  = cmd_valid_q & cmd_ready;
  // A response counts only for a command that is accepted now or already was
  assign got_rsp = rsp_valid & (acc_q | accept);

  // Next-state: sequencing, capture, abort and timeout
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    pending_d     = pending_q | int_fall;
    tmo_d         = tmo_q;
    cnt_d         = cnt_q;
    xh_d          = xh_q;
    xl_d          = xl_q;
    yh_d          = yh_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_op_d      = cmd_op_q;
    cmd_data_d    = cmd_data_q;
    touch_valid_d = 1'b0;
    touch_count_d = touch_count_q;
    touch_x_d     = touch_x_q;
    touch_y_d     = touch_y_q;
    err_nack_d    = 1'b0;
    err_timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pending_q && enable) begin
          pending_d = int_fall;  // an edge arriving now still counts
          state_d   = StAddrW;
        end
      end
      StPublish: begin
        state_d = StIdle;
      end
      default: begin
        if (accept) begin
          cmd_valid_d = 1'b0;
          acc_d       = 1'b1;
        end
        if (got_rsp) begin
          if (state_q == StAbort) begin
            err_nack_d = 1'b1;
            state_d    = StIdle;
          end else if (is_write_state(state_q) && rsp_nack) begin
            state_d = StAbort;
          end else begin
            state_d = next_state(state_q);
            if (is_read_state(state_q)) begin
              case (rd_index(state_q))
                BYTE_COUNT: cnt_d = rsp_data[3:0];
                BYTE_XH:    xh_d  = rsp_data[3:0];
                BYTE_XL:    xl_d  = rsp_data;
                BYTE_YH:    yh_d  = rsp_data[3:0];
                BYTE_YL: begin
                  touch_valid_d = 1'b1;
                  touch_count_d = cnt_q;
                  touch_x_d     = {xh_q, xl_q};
                  touch_y_d     = {yh_q, rsp_data};
                end
                default: ;
              endcase
            end
          end
        end else if (tmo_q == TmoLast) begin
          // Master assumed hung: drop the command without a STOP
          err_timeout_d = 1'b1;
          state_d       = StIdle;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    endcase

    // Every state change starts a fresh command phase
    if (state_d != state_q) begin
      tmo_d       = '0;
      acc_d       = 1'b0;
      cmd_valid_d = is_cmd_state(state_d);
      cmd_op_d    = op_of(state_d);
      cmd_data_d  = data_of(state_d);
    end

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      acc_q         <= 1'b0;
      pending_q     <= 1'b0;
      tmo_q         <= '0;
      cnt_q         <= '0;
      xh_q          <= '0;
      xl_q          <= '0;
      yh_q          <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_op_q      <= '0;
      cmd_data_q    <= '0;
      busy_q        <= 1'b0;
      touch_valid_q <= 1'b0;
      touch_count_q <= '0;
      touch_x_q     <= '0;
      touch_y_q     <= '0;
      err_nack_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      pending_q     <= pending_d;
      tmo_q         <= tmo_d;
      cnt_q         <= cnt_d;
      xh_q          <= xh_d;
      xl_q          <= xl_d;
      yh_q          <= yh_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_op_q      <= cmd_op_d;
      cmd_data_q    <= cmd_data_d;
      busy_q        <= busy_d;
      touch_valid_q <= touch_valid_d;
      touch_count_q <= touch_count_d;
      touch_x_q     <= touch_x_d;
      touch_y_q     <= touch_y_d;
      err_nack_q    <= err_nack_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_op      = cmd_op_q;
  assign cmd_data    = cmd_data_q;
  assign busy        = busy_q;
  assign touch_valid = touch_valid_q;
  assign touch_count = touch_count_q;
  assign touch_x     = touch_x_q;
  assign touch_y     = touch_y_q;
  assign err_nack    = err_nack_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mtl2_touch_sequencer.sv
// Self-checking bench for mtl2_touch_sequencer: a behavioural byte-level I2C
// master answers commands, a vector table drives full frames, and directed
// sequences cover NACK, timeout, edge collapsing, reset and enable.
module tb_mtl2_touch_sequencer;

  localparam int unsigned TMO = 64;

  logic        clk_50 = 1'b0;
  logic        reset_n, enable, touch_int_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid, rsp_nack;
  logic [7:0]  rsp_data;
  logic        busy, touch_valid, err_nack, err_timeout;
  logic [3:0]  touch_count;
  logic [11:0] touch_x, touch_y;

  always #5 clk_50 = ~clk_50;

  mtl2_touch_sequencer #(
    .DEV_ADDR       (7'h38),
    .REG_BASE       (8'h02),
    .TIMEOUT_CYCLES (TMO),
    .TW             (20)
  ) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .enable      (enable),
    .touch_int_n (touch_int_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_nack    (rsp_nack),
    .busy        (busy),
    .touch_valid (touch_valid),
    .touch_count (touch_count),
    .touch_x     (touch_x),
    .touch_y     (touch_y),
    .err_nack    (err_nack),
    .err_timeout (err_timeout)
  );

  typedef struct {
    logic [4:0][7:0] bytes;   // {count, XH, XL, YH, YL}
    int              wait_c;  // cycles cmd_ready stays low per command
    logic [3:0]      cnt;
    logic [11:0]     x;
    logic [11:0]     y;
  } vec_t;

  vec_t       vecs [5];
  logic [2:0] exp_op [8];
  logic [7:0] exp_data [8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Master model configuration and state
  int         ready_wait = 0;
  int         wait_cnt = 0;
  int         hang_at = -1;
  int         nack_at = -1;
  int         cmd_idx = 0;
  int         rd_ptr = 0;
  logic [7:0] rd_bytes [5];
  bit         showing = 1'b0;
  logic [2:0] held_op;
  logic [7:0] held_data;

  // Observed events
  logic [2:0]  log_op [$];
  logic [7:0]  log_data [$];
  int          log_cyc [$];
  int          tv_cnt, tv_cyc, nack_cnt, tmo_cnt, tmo_cyc, first_cmd_cyc;
  logic [3:0]  cap_cnt;
  logic [11:0] cap_x, cap_y;
  logic        tmo_cmd_valid, tmo_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_events();
    tv_cnt = 0; nack_cnt = 0; tmo_cnt = 0; first_cmd_cyc = -1;
    cmd_idx = 0; rd_ptr = 0; wait_cnt = 0; showing = 1'b0;
    log_op.delete(); log_data.delete(); log_cyc.delete();
  endtask

  task automatic load_bytes(input logic [4:0][7:0] b);
    for (int i = 0; i < 5; i++) rd_bytes[i] = b[4-i];
  endtask

  // One clock: sample DUT outputs 1ns after the edge and answer as the master
  task automatic cycle();
    @(posedge clk_50);
    #1;
    cyc++;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
    if (touch_valid) begin
      tv_cnt++; tv_cyc = cyc;
      cap_cnt = touch_count; cap_x = touch_x; cap_y = touch_y;
    end
    if (err_nack) nack_cnt++;
    if (err_timeout) begin
      tmo_cnt++; tmo_cyc = cyc; tmo_cmd_valid = cmd_valid; tmo_busy = busy;
    end
    if (cmd_valid) begin
      if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
      if (showing) begin
        chk("cmd_op_stable", 32'(cmd_op), 32'(held_op));
        chk("cmd_data_stable", 32'(cmd_data), 32'(held_data));
      end else begin
        showing = 1'b1; held_op = cmd_op; held_data = cmd_data;
      end
      if (wait_cnt < ready_wait) begin
        wait_cnt++;
      end else begin
        cmd_ready = 1'b1; wait_cnt = 0; showing = 1'b0;
        log_op.push_back(cmd_op); log_data.push_back(cmd_data); log_cyc.push_back(cyc);
        if (cmd_idx != hang_at) begin
          rsp_valid = 1'b1;
          rsp_nack  = (cmd_idx == nack_at);
          if (cmd_op == 3'd3 || cmd_op == 3'd4) begin
            rsp_data = rd_bytes[rd_ptr % 5];
            rd_ptr++;
          end
        end
        cmd_idx++;
      end
    end else begin
      showing = 1'b0;
    end
  endtask

  task automatic int_edge();
    touch_int_n = 1'b0;
    repeat (3) cycle();
    touch_int_n = 1'b1;
    cycle();
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (busy !== lvl && n < budget) begin
      cycle();
      n++;
    end
    chk(name, 32'(busy), 32'(lvl));
  endtask

  // Run until n publishes have happened and the block is idle again
  task automatic run_until_pub(input int n, input int budget, input string name);
    int k;
    k = 0;
    while ((tv_cnt < n || busy) && k < budget) begin
      cycle();
      k++;
    end
    chk(name, 32'(tv_cnt), 32'(n));
  endtask

  task automatic check_frame_log(input int base, input string tag);
    for (int j = 0; j < 8; j++) begin
      if (base + j < log_op.size()) begin
        chk($sformatf("%s_op%0d", tag, j), 32'(log_op[base+j]), 32'(exp_op[j]));
        chk($sformatf("%s_data%0d", tag, j), 32'(log_data[base+j]), 32'(exp_data[j]));
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark;
    int n;

    vecs[0] = '{bytes: {8'h01, 8'h02, 8'h1F, 8'h01, 8'hE0}, wait_c: 0,
                cnt: 4'h1, x: 12'h21F, y: 12'h1E0};
    vecs[1] = '{bytes: {8'h01, 8'h02, 8'h1F, 8'h01, 8'hE0}, wait_c: 5,
                cnt: 4'h1, x: 12'h21F, y: 12'h1E0};
    vecs[2] = '{bytes: {8'h05, 8'hF3, 8'h4A, 8'h8C, 8'h7B}, wait_c: 0,
                cnt: 4'h5, x: 12'h34A, y: 12'hC7B};
    vecs[3] = '{bytes: {8'h0A, 8'h0F, 8'hFF, 8'h0F, 8'hFF}, wait_c: 2,
                cnt: 4'hA, x: 12'hFFF, y: 12'hFFF};
    vecs[4] = '{bytes: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, wait_c: 1,
                cnt: 4'h0, x: 12'h000, y: 12'h000};
    exp_op   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    exp_data = '{8'h70, 8'h02, 8'h71, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    reset_n = 1'b0; enable = 1'b1; touch_int_n = 1'b1;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
    clear_events();
    repeat (3) cycle();
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_cmd_op", 32'(cmd_op), 0);
    chk("rst_cmd_data", 32'(cmd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_touch_valid", 32'(touch_valid), 0);
    chk("rst_touch_count", 32'(touch_count), 0);
    chk("rst_touch_x", 32'(touch_x), 0);
    chk("rst_touch_y", 32'(touch_y), 0);
    chk("rst_err_nack", 32'(err_nack), 0);
    chk("rst_err_timeout", 32'(err_timeout), 0);
    reset_n = 1'b1;
    repeat (5) cycle();
    chk("idle_without_int", 32'(busy), 0);

    // Table-driven full frames
    for (int i = 0; i < 5; i++) begin
      clear_events();
      ready_wait = vecs[i].wait_c;
      load_bytes(vecs[i].bytes);
      int_edge();
      run_until_pub(1, 400, $sformatf("v%0d_pub", i));
      repeat (3) cycle();
      chk($sformatf("v%0d_log_len", i), 32'(log_op.size()), 8);
      check_frame_log(0, $sformatf("v%0d", i));
      chk($sformatf("v%0d_tv_pulses", i), 32'(tv_cnt), 1);
      chk($sformatf("v%0d_count", i), 32'(cap_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_x", i), 32'(cap_x), 32'(vecs[i].x));
      chk($sformatf("v%0d_y", i), 32'(cap_y), 32'(vecs[i].y));
      chk($sformatf("v%0d_latency", i), 32'(tv_cyc - first_cmd_cyc),
          32'(8 * (vecs[i].wait_c + 1)));
      chk($sformatf("v%0d_x_hold", i), 32'(touch_x), 32'(vecs[i].x));
      chk($sformatf("v%0d_busy_low", i), 32'(busy), 0);
    end

    // NACK on ADDR_W: STOP then err_nack, no publish; next edge works
    ready_wait = 0;
    load_bytes(vecs[0].bytes);
    clear_events();
    nack_at = 0;
    int_edge();
    wait_busy(1'b0, 100, "nack_idle");
    repeat (3) cycle();
    nack_at = -1;
    chk("nack_log_len", 32'(log_op.size()), 2);
    if (log_op.size() >= 2) chk("nack_stop_op", 32'(log_op[1]), 5);
    chk("nack_pulses", 32'(nack_cnt), 1);
    chk("nack_no_publish", 32'(tv_cnt), 0);
    clear_events();
    int_edge();
    run_until_pub(1, 200, "nack_restart_pub");
    chk("nack_restart_x", 32'(cap_x), 32'h21F);
    chk("nack_restart_nack", 32'(nack_cnt), 0);

    // REG accepted but never answered: timeout after TMO cycles of waiting
    clear_events();
    hang_at = 1;
    int_edge();
    n = 0;
    while (tmo_cnt == 0 && n < 300) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    hang_at = -1;
    chk("tmo_pulses", 32'(tmo_cnt), 1);
    if (log_cyc.size() >= 2) chk("tmo_latency", 32'(tmo_cyc - log_cyc[1]), 32'(TMO));
    chk("tmo_cmd_valid", 32'(tmo_cmd_valid), 0);
    chk("tmo_busy", 32'(tmo_busy), 0);
    chk("tmo_no_stop", 32'(log_op.size()), 2);
    chk("tmo_no_nack", 32'(nack_cnt), 0);
    chk("tmo_no_publish", 32'(tv_cnt), 0);

    // Second edge around RD2 gives exactly one more full frame
    clear_events();
    ready_wait = 1;
    int_edge();
    n = 0;
    while (log_op.size() < 5 && n < 100) begin
      cycle();
      n++;
    end
    chk("edge2_reached_rd2", 32'(log_op.size() >= 5), 1);
    int_edge();
    run_until_pub(2, 400, "edge2_pub");
    repeat (20) cycle();
    chk("edge2_pub_total", 32'(tv_cnt), 2);
    chk("edge2_log_len", 32'(log_op.size()), 16);
    check_frame_log(8, "edge2_second");

    // Three edges while busy collapse into one extra frame
    clear_events();
    ready_wait = 5;
    int_edge();
    wait_busy(1'b1, 50, "edge3_busy");
    repeat (3) int_edge();
    run_until_pub(2, 600, "edge3_pub");
    repeat (30) cycle();
    chk("edge3_pub_total", 32'(tv_cnt), 2);
    chk("edge3_log_len", 32'(log_op.size()), 16);
    chk("edge3_idle", 32'(busy), 0);

    // Reset during RD1: everything cleared, nothing published
    clear_events();
    ready_wait = 2;
    int_edge();
    n = 0;
    while (!(cmd_valid && log_op.size() == 4) && n < 100) begin
      cycle();
      n++;
    end
    chk("rst_mid_reached_rd1", 32'(cmd_op), 3);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    wait_cnt = 0; showing = 1'b0;
    chk("rst_mid_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_touch_x", 32'(touch_x), 0);
    chk("rst_mid_touch_y", 32'(touch_y), 0);
    chk("rst_mid_touch_count", 32'(touch_count), 0);
    mark = log_op.size();
    repeat (30) cycle();
    chk("rst_mid_no_cmd", 32'(log_op.size()), 32'(mark));
    chk("rst_mid_no_publish", 32'(tv_cnt), 0);

    // enable low holds off a pending edge until it returns high
    ready_wait = 0;
    clear_events();
    enable = 1'b0;
    int_edge();
    repeat (30) cycle();
    chk("en0_no_cmd", 32'(log_op.size()), 0);
    chk("en0_idle", 32'(busy), 0);
    enable = 1'b1;
    run_until_pub(1, 200, "en1_pub");
    chk("en1_count", 32'(cap_cnt), 1);
    chk("en1_y", 32'(cap_y), 32'h1E0);
    chk("en1_log_len", 32'(log_op.size()), 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
